// File: rtl/vfu_mask_router.sv
// vfu_mask_router: steers vid-tagged mask beats from the mask unit into per-FU FIFOs.
// A beat goes only to the lowest-indexed FU whose active masked instruction vid matches.
// Each FU drains its own FIFO at its own rate.
module vfu_mask_router #(
    parameter int unsigned NrFUs         = 2,
    parameter int unsigned StrbWidth     = 8,
    parameter int unsigned NrVInsn       = 8,
    parameter int unsigned MaskFifoDepth = 2,
    parameter int unsigned VidWidth      = $clog2(NrVInsn)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [StrbWidth-1:0]                          mask_i,
    input  logic [VidWidth-1:0]                           mask_vid_i,
    input  logic                                          mask_valid_i,
    output logic                                          mask_ready_o,
    input  logic [NrFUs*VidWidth-1:0]                     fu_vid_i,
    input  logic [NrFUs-1:0]                              fu_vid_valid_i,
    input  logic [NrFUs-1:0]                              fu_flush_i,
    output logic [NrFUs*StrbWidth-1:0]                    fu_mask_o,
    output logic [NrFUs-1:0]                              fu_mask_valid_o,
    input  logic [NrFUs-1:0]                              fu_mask_ready_i,
    output logic [NrFUs*$clog2(MaskFifoDepth+1)-1:0]      fu_mask_cnt_o,
    output logic                                          multi_match_o
);

    localparam int unsigned CntWidth = $clog2(MaskFifoDepth + 1);
    localparam int unsigned PtrWidth = (MaskFifoDepth > 1) ? $clog2(MaskFifoDepth) : 1;
    localparam int unsigned TgtWidth = (NrFUs > 1) ? $clog2(NrFUs) : 1;

    logic [StrbWidth-1:0] mem    [NrFUs][MaskFifoDepth];
    logic [PtrWidth-1:0]  rd_ptr [NrFUs];
    logic [PtrWidth-1:0]  wr_ptr [NrFUs];
    logic [CntWidth-1:0]  cnt    [NrFUs];

    logic [NrFUs-1:0]    match;
    logic [NrFUs-1:0]    full;
    logic [NrFUs-1:0]    push;
    logic [NrFUs-1:0]    pop;
    logic [TgtWidth-1:0] target;
    logic                multi;

    // Wrap a FIFO pointer modulo the depth.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(MaskFifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Per-FU vid match and FIFO status.
    always_comb begin
        match = '0;
        full  = '0;
        for (int f = 0; f < NrFUs; f++) begin
            match[f] = fu_vid_valid_i[f] && (fu_vid_i[f*VidWidth +: VidWidth] == mask_vid_i);
            full[f]  = (cnt[f] == CntWidth'(MaskFifoDepth));
        end
    end

    // Pick the lowest matching FU; flag a beat that more than one FU claims.
    always_comb begin
        logic seen;
        target = '0;
        multi  = 1'b0;
        seen   = 1'b0;
        for (int f = NrFUs - 1; f >= 0; f--) begin
            if (match[f]) begin
                target = TgtWidth'(f);
            end
        end
        for (int f = 0; f < NrFUs; f++) begin
            if (match[f]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

    // Ready ignores a same-cycle pop on a full target so it never depends on fu_mask_ready_i.
    always_comb begin
        mask_ready_o = (|match) && !full[target] && !fu_flush_i[target];
        push = '0;
        pop  = '0;
        for (int f = 0; f < NrFUs; f++) begin
            push[f] = mask_valid_i && mask_ready_o && (target == TgtWidth'(f));
            pop[f]  = fu_mask_valid_o[f] && fu_mask_ready_i[f];
        end
    end

    // Present each FIFO head, occupancy and valid; the head is held, not cleared, when empty.
    always_comb begin
        fu_mask_o       = '0;
        fu_mask_cnt_o   = '0;
        fu_mask_valid_o = '0;
        for (int f = 0; f < NrFUs; f++) begin
            fu_mask_o[f*StrbWidth +: StrbWidth] = rst_i ? '0 : mem[f][rd_ptr[f]];
            fu_mask_cnt_o[f*CntWidth +: CntWidth] = cnt[f];
            fu_mask_valid_o[f] = (cnt[f] != '0);
        end
    end

    // FIFO state update; flush wins over pop and push is already blocked by ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            multi_match_o <= 1'b0;
            for (int f = 0; f < NrFUs; f++) begin
                cnt[f]    <= '0;
                rd_ptr[f] <= '0;
                wr_ptr[f] <= '0;
                for (int d = 0; d < MaskFifoDepth; d++) begin
                    mem[f][d] <= '0;
                end
            end
        end else begin
            multi_match_o <= mask_valid_i && multi;
            for (int f = 0; f < NrFUs; f++) begin
                if (fu_flush_i[f]) begin
                    cnt[f]    <= '0;
                    rd_ptr[f] <= '0;
                    wr_ptr[f] <= '0;
                end else begin
                    if (push[f]) begin
                        mem[f][wr_ptr[f]] <= mask_i;
                        wr_ptr[f]         <= ptr_inc(wr_ptr[f]);
                    end
                    if (pop[f]) begin
                        rd_ptr[f] <= ptr_inc(rd_ptr[f]);
                    end
                    if (push[f] && !pop[f]) begin
                        cnt[f] <= cnt[f] + 1'b1;
                    end else if (pop[f] && !push[f]) begin
                        cnt[f] <= cnt[f] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vfu_mask_router.sv
// Bench for vfu_mask_router: directed scenarios then random traffic, all checked
// against a queue-per-FU reference model.
module tb_vfu_mask_router;

    localparam int NF    = 2;
    localparam int SW    = 8;
    localparam int VW    = 3;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [SW-1:0]     mask = '0;
    logic [VW-1:0]     mvid = '0;
    logic              mvalid = 1'b0;
    logic              mready;
    logic [VW-1:0]     fvid [NF];
    logic [NF-1:0]     fvv = '0;
    logic [NF-1:0]     flush = '0;
    logic [NF-1:0]     frdy = '0;
    logic [NF*VW-1:0]  fvid_flat;
    logic [NF*SW-1:0]  fmask;
    logic [NF-1:0]     fvalid;
    logic [NF*CW-1:0]  fcnt;
    logic              multi;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue of pending beats per FU plus the delayed multi-match flag.
    logic [SW-1:0] q [NF][$];
    logic          multi_exp = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        fvid_flat = '0;
        for (int f = 0; f < NF; f++) fvid_flat[f*VW +: VW] = fvid[f];
    end

    vfu_mask_router dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .mask_i          (mask),
        .mask_vid_i      (mvid),
        .mask_valid_i    (mvalid),
        .mask_ready_o    (mready),
        .fu_vid_i        (fvid_flat),
        .fu_vid_valid_i  (fvv),
        .fu_flush_i      (flush),
        .fu_mask_o       (fmask),
        .fu_mask_valid_o (fvalid),
        .fu_mask_ready_i (frdy),
        .fu_mask_cnt_o   (fcnt),
        .multi_match_o   (multi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare DUT against the model mid-cycle, advance the model, then step to posedge+1.
    task automatic cycle();
        int tgt;
        int nm;
        logic rdy_exp;
        @(negedge clk);
        tgt = -1;
        nm  = 0;
        for (int f = NF - 1; f >= 0; f--) begin
            if (fvv[f] && fvid[f] == mvid) begin
                tgt = f;
                nm++;
            end
        end
        rdy_exp = (tgt >= 0) && (q[tgt].size() < DEPTH) && !flush[tgt];
        chk("ready", mready, rdy_exp);
        chk("multi", multi, multi_exp);
        for (int f = 0; f < NF; f++) begin
            chk($sformatf("valid%0d", f), fvalid[f], q[f].size() > 0);
            chk($sformatf("cnt%0d", f), fcnt[f*CW +: CW], q[f].size());
            if (q[f].size() > 0) chk($sformatf("head%0d", f), fmask[f*SW +: SW], q[f][0]);
        end
        for (int f = 0; f < NF; f++) begin
            if (flush[f]) q[f].delete();
            else if (q[f].size() > 0 && frdy[f]) void'(q[f].pop_front());
        end
        if (mvalid && rdy_exp) q[tgt].push_back(mask);
        multi_exp = mvalid && (nm >= 2);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_mask", fmask, '0);
        for (int f = 0; f < NF; f++) q[f].delete();
        multi_exp = 1'b0;
        rst = 1'b0;
    endtask

    task automatic beat(input logic [SW-1:0] m, input logic [VW-1:0] v);
        mask = m; mvid = v; mvalid = 1'b1;
        cycle();
        mvalid = 1'b0;
    endtask

    initial begin
        for (int f = 0; f < NF; f++) fvid[f] = '0;
        do_reset(2);

        // Reset with beats queued.
        fvid[0] = 3'd3; fvv = 2'b01;
        beat(8'h11, 3'd3);
        beat(8'h12, 3'd3);
        do_reset(2);
        fvv = 2'b00; mvalid = 1'b1; mvid = 3'd3;
        #1;
        chk("rst_ready", mready, 1'b0);
        cycle();
        mvalid = 1'b0;

        // Steering to FU1 only.
        fvid[0] = 3'd3; fvid[1] = 3'd5; fvv = 2'b11;
        beat(8'hA5, 3'd5);
        chk("steer_v1", fvalid[1], 1'b1);
        chk("steer_d1", fmask[SW +: SW], 8'hA5);
        chk("steer_v0", fvalid[0], 1'b0);
        frdy = 2'b10; cycle(); frdy = 2'b00;

        // Backpressure on FU0.
        beat(8'h21, 3'd3);
        beat(8'h22, 3'd3);
        mask = 8'h23; mvid = 3'd3; mvalid = 1'b1;
        #1;
        chk("bp_cnt", fcnt[0 +: CW], 2);
        chk("bp_ready", mready, 1'b0);
        cycle();
        frdy = 2'b01; cycle(); frdy = 2'b00;
        chk("bp_retry", mready, 1'b1);
        cycle();
        mvalid = 1'b0;
        frdy = 2'b11;
        repeat (3) cycle();

        // Concurrent interleaved streams.
        fvid[0] = 3'd1; fvid[1] = 3'd2;
        beat(8'h01, 3'd1);
        beat(8'h02, 3'd2);
        beat(8'h03, 3'd1);
        beat(8'h04, 3'd2);
        repeat (2) cycle();

        // Flush FU1 against a simultaneous push.
        frdy = 2'b00;
        beat(8'h55, 3'd1);
        beat(8'h61, 3'd2);
        beat(8'h62, 3'd2);
        flush = 2'b10; mask = 8'h77; mvid = 3'd2; mvalid = 1'b1;
        #1;
        chk("flush_ready", mready, 1'b0);
        cycle();
        chk("flush_cnt1", fcnt[CW +: CW], 0);
        chk("flush_cnt0", fcnt[0 +: CW], 1);
        cycle();
        flush = 2'b00; mvalid = 1'b0;
        frdy = 2'b11;
        repeat (2) cycle();

        // Multi-match and unknown vid stall.
        frdy = 2'b00;
        fvid[0] = 3'd4; fvid[1] = 3'd4;
        beat(8'h99, 3'd4);
        chk("mm_pulse", multi, 1'b1);
        chk("mm_cnt0", fcnt[0 +: CW], 1);
        cycle();
        chk("mm_clear", multi, 1'b0);
        mask = 8'hC7; mvid = 3'd7; mvalid = 1'b1;
        repeat (3) cycle();
        fvid[1] = 3'd7;
        cycle();
        mvalid = 1'b0;
        chk("stall_take", fvalid[1], 1'b1);
        frdy = 2'b11;
        repeat (3) cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            for (int f = 0; f < NF; f++) begin
                if ($urandom_range(0, 7) == 0) fvid[f] = VW'($urandom_range(0, 7));
            end
            fvv    = NF'($urandom);
            frdy   = NF'($urandom);
            flush  = '0;
            for (int f = 0; f < NF; f++) flush[f] = ($urandom_range(0, 15) == 0);
            mvalid = $urandom_range(0, 3) != 0;
            mask   = SW'($urandom);
            mvid   = $urandom_range(0, 1) ? fvid[$urandom_range(0, NF - 1)]
                                          : VW'($urandom_range(0, 7));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
